// File: rtl/data_read_capture_pkg.sv
// rtl/data_read_capture_pkg.sv - shared encodings for the capture sequencer
package data_read_capture_pkg;

    localparam int DEF_ADDR_W = 12;

    typedef enum logic [1:0] {
        TRIG_IMM  = 2'd0,
        TRIG_EXT  = 2'd1,
        TRIG_RISE = 2'd2,
        TRIG_FALL = 2'd3
    } trig_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_e;

endpackage

// File: rtl/data_read_capture_trig.sv
// rtl/data_read_capture_trig.sv - trigger qualifier: edge detect and pending logic
module data_read_trig
    import data_read_capture_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       arm,
    input  logic       active,
    input  trig_mode_e mode,
    input  logic [1:0] ch,
    input  logic       ext_trig,
    input  logic [3:0] din,
    input  logic       din_valid,
    output logic       trig_hit
);

    logic ext_q;
    logic trig_pending;
    logic prev_bit;
    logic prev_valid;
    logic ext_rise;
    logic cur_bit;

    assign ext_rise = ext_trig & ~ext_q;
    assign cur_bit  = din[ch];

    // ext_trig history runs every cycle so a pulse during a din_valid gap is not lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q        <= 1'b0;
            trig_pending <= 1'b0;
            prev_bit     <= 1'b0;
            prev_valid   <= 1'b0;
        end else begin
            ext_q <= ext_trig;
            if (arm) begin
                trig_pending <= 1'b0;
                prev_bit     <= 1'b0;
                prev_valid   <= 1'b0;
            end else if (active) begin
                if (ext_rise)
                    trig_pending <= 1'b1;
                if (din_valid) begin
                    prev_bit   <= cur_bit;
                    prev_valid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        trig_hit = 1'b0;
        if (active && din_valid) begin
            case (mode)
                TRIG_IMM:  trig_hit = 1'b1;
                TRIG_EXT:  trig_hit = trig_pending | ext_rise;
                TRIG_RISE: trig_hit = prev_valid & ~prev_bit & cur_bit;
                TRIG_FALL: trig_hit = prev_valid & prev_bit & ~cur_bit;
                default:   trig_hit = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/data_read_capture.sv
// rtl/data_read_capture.sv - arm/trigger/capture sequencer driving the LVDS buffer write port
module data_read_capture
    import data_read_capture_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              wr_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  capture_len,
    input  logic [1:0]        trig_mode,
    input  logic [1:0]        trig_ch,
    input  logic              ext_trig,
    input  logic [3:0]        din,
    input  logic              din_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  count
);

    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(1) << ADDR_W;

    cap_state_e        state;
    cap_state_e        state_next;
    logic [LEN_W-1:0]  len_q;
    trig_mode_e        mode_q;
    logic [1:0]        ch_q;
    logic              arm;
    logic              trig_hit;
    logic              wr_go;
    logic              first;
    logic              finish;
    logic [LEN_W-1:0]  count_next;
    logic [LEN_W-1:0]  len_eff;

    assign arm = (state == ST_IDLE) && start && !abort;

    // zero and oversize requests both mean a full-depth capture
    assign len_eff = (capture_len == '0 || capture_len > DEPTH) ? DEPTH : capture_len;

    data_read_trig u_trig (
        .clk       (wr_clk),
        .rst       (rst),
        .arm       (arm),
        .active    (state == ST_ARMED),
        .mode      (mode_q),
        .ch        (ch_q),
        .ext_trig  (ext_trig),
        .din       (din),
        .din_valid (din_valid),
        .trig_hit  (trig_hit)
    );

    always_comb begin
        state_next = state;
        wr_go      = 1'b0;
        first      = 1'b0;
        finish     = 1'b0;
        count_next = count + LEN_W'(1);
        case (state)
            ST_IDLE: begin
                if (arm)
                    state_next = ST_ARMED;
            end
            ST_ARMED: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (trig_hit) begin
                    wr_go      = 1'b1;
                    first      = 1'b1;
                    count_next = LEN_W'(1);
                    if (len_q == LEN_W'(1)) begin
                        finish     = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (din_valid) begin
                    wr_go = 1'b1;
                    if (count_next == len_q) begin
                        finish     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            len_q   <= DEPTH;
            mode_q  <= TRIG_IMM;
            ch_q    <= 2'd0;
            wr_addr <= '0;
            wr_data <= 4'd0;
            wr_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            count   <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != ST_IDLE);
            wr_en <= wr_go;
            if (arm) begin
                len_q  <= len_eff;
                mode_q <= trig_mode_e'(trig_mode);
                ch_q   <= trig_ch;
                done   <= 1'b0;
                count  <= '0;
            end
            // count equals the next free address, so it doubles as the write pointer
            if (wr_go) begin
                wr_addr <= first ? '0 : count[ADDR_W-1:0];
                wr_data <= din;
                count   <= count_next;
            end
            if (finish)
                done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_read_capture.sv
// tb/tb_data_read_capture.sv - scoreboard bench for data_read_capture
module tb_data_read_capture;

    localparam int ADDR_W = 12;
    localparam int LEN_W  = 13;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [3:0]        d;
    } exp_t;

    logic              wr_clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [LEN_W-1:0]  capture_len = '0;
    logic [1:0]        trig_mode = 2'd0;
    logic [1:0]        trig_ch = 2'd0;
    logic              ext_trig = 1'b0;
    logic [3:0]        din = 4'd0;
    logic              din_valid = 1'b0;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_data;
    logic              wr_en;
    logic              busy;
    logic              done;
    logic [LEN_W-1:0]  count;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    data_read_capture #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .wr_clk      (wr_clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .capture_len (capture_len),
        .trig_mode   (trig_mode),
        .trig_ch     (trig_ch),
        .ext_trig    (ext_trig),
        .din         (din),
        .din_valid   (din_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .busy        (busy),
        .done        (done),
        .count       (count)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // monitor: every write strobe must match the oldest expected write
    initial begin
        exp_t e;
        forever begin
            @(posedge wr_clk);
            #1;
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_write: got addr %0d data %0h expected no write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr_data", {wr_addr, wr_data}, {e.a, e.d});
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] d);
        @(negedge wr_clk);
        start     = 1'b0;
        abort     = 1'b0;
        din_valid = v;
        din       = d;
    endtask

    task automatic do_start(input int len, input logic [1:0] mode, input logic [1:0] ch);
        @(negedge wr_clk);
        start       = 1'b1;
        abort       = 1'b0;
        din_valid   = 1'b0;
        capture_len = LEN_W'(len);
        trig_mode   = mode;
        trig_ch     = ch;
    endtask

    task automatic push(input int a, input logic [3:0] d);
        exp_t e;
        e.a = ADDR_W'(a);
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic finish_check(input string name, input logic exp_done, input int exp_count);
        drive(1'b0, 4'd0);
        drive(1'b0, 4'd0);
        check({name, "_done"}, 32'(done), 32'(exp_done));
        check({name, "_count"}, 32'(count), 32'(exp_count));
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    logic [3:0] seq2 [5];
    int         lens [2];

    initial begin
        seq2[0] = 4'd0; seq2[1] = 4'd0; seq2[2] = 4'd2; seq2[3] = 4'd3; seq2[4] = 4'd0;
        lens[0] = 0;    lens[1] = 8191;

        #12;
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        @(negedge wr_clk);
        rst = 1'b0;

        // immediate trigger, continuous samples, one-cycle write latency
        do_start(8, 2'd0, 2'd0);
        for (int i = 0; i < 8; i++) begin
            push(i, 4'(i));
            drive(1'b1, 4'(i));
            if (i == 0) begin
                check("m0_busy_armed", 32'(busy), 32'd1);
                @(posedge wr_clk);
                #1;
                check("m0_first_latency", 32'(wr_en), 32'd1);
            end
        end
        finish_check("m0", 1'b1, 8);

        // rising edge on channel 1
        do_start(3, 2'd2, 2'd1);
        push(0, 4'd2); push(1, 4'd3); push(2, 4'd0);
        for (int i = 0; i < 5; i++) drive(1'b1, seq2[i]);
        finish_check("m2", 1'b1, 3);

        // external trigger pulse during a din_valid gap, then 4 samples
        do_start(4, 2'd1, 2'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'd9);
            ext_trig = (i == 1);
        end
        ext_trig = 1'b0;
        push(0, 4'hA); push(1, 4'hB); push(2, 4'hC); push(3, 4'hD);
        drive(1'b1, 4'hA); drive(1'b1, 4'hB); drive(1'b1, 4'hC); drive(1'b1, 4'hD);
        finish_check("m1", 1'b1, 4);

        // full-depth captures: zero and oversize lengths; extra samples must not write
        foreach (lens[k]) begin
            do_start(lens[k], 2'd0, 2'd0);
            for (int i = 0; i < 4096; i++) begin
                push(i, 4'(i * 7));
                drive(1'b1, 4'(i * 7));
            end
            drive(1'b1, 4'h5);
            drive(1'b1, 4'h6);
            finish_check("full", 1'b1, 4096);
        end

        // din_valid stalls must not leave address gaps
        do_start(10, 2'd0, 2'd0);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) push(i / 2, 4'(15 - i / 2));
            drive((i % 2) == 0, 4'(15 - i / 2));
        end
        finish_check("stall", 1'b1, 10);

        // abort after 5 samples
        do_start(20, 2'd0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            push(i, 4'(i + 3));
            drive(1'b1, 4'(i + 3));
        end
        @(negedge wr_clk);
        abort = 1'b1;
        din_valid = 1'b1;
        drive(1'b1, 4'h1);
        check("abort_busy", 32'(busy), 32'd0);
        drive(1'b1, 4'h2);
        drive(1'b1, 4'h3);
        finish_check("abort", 1'b0, 5);

        // start and abort together: stays idle
        @(negedge wr_clk);
        start = 1'b1;
        abort = 1'b1;
        capture_len = LEN_W'(4);
        trig_mode = 2'd0;
        drive(1'b1, 4'h7);
        check("start_abort_busy", 32'(busy), 32'd0);
        drive(1'b1, 4'h8);
        finish_check("start_abort", 1'b0, 5);

        // asynchronous reset mid-capture
        do_start(20, 2'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            push(i, 4'(i + 1));
            drive(1'b1, 4'(i + 1));
        end
        @(negedge wr_clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_wr_en", 32'(wr_en), 32'd0);
        check("rst_mid_outputs", {20'(wr_addr), wr_data, 3'(count), busy, done, 3'd0}, 32'd0);
        check("rst_mid_count", 32'(count), 32'd0);
        @(negedge wr_clk);
        rst = 1'b0;
        drive(1'b1, 4'h4);
        drive(1'b1, 4'h5);
        finish_check("rst_mid", 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
